// File: rtl/step_ring_fsm.sv
// step_ring_fsm: programmable N-state ring sequencer stepped by data_in.
// Ports: clk, reset (sync, active-high), data_in (step request),
//   dir (0 fwd / 1 bwd), hold, load + load_state, pat_we + pat_in
//   (per-state output pattern), data_out = pattern[state], state_out,
//   wrap_pulse / load_err (registered one-cycle pulses), step_count
//   (saturating count of accepted steps).
module step_ring_fsm #(
   parameter int NUM_STATES = 4,
   parameter int RESET_STATE = 1,
   parameter int WRAP_TO = 1,
   parameter logic [NUM_STATES-1:0] OUT_PATTERN = NUM_STATES'(4'b1010),
   parameter int EDGE_MODE = 0,
   parameter int CNT_W = 8,
   localparam int SW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_in,
   input  logic                  dir,
   input  logic                  hold,
   input  logic                  load,
   input  logic [SW-1:0]         load_state,
   input  logic                  pat_we,
   input  logic [NUM_STATES-1:0] pat_in,
   output logic                  data_out,
   output logic [SW-1:0]         state_out,
   output logic                  wrap_pulse,
   output logic                  load_err,
   output logic [CNT_W-1:0]      step_count
);

   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_LOAD,
      ACT_LERR,
      ACT_HOLD,
      ACT_FWD,
      ACT_BWD
   } act_t;

   localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
   localparam logic [SW-1:0] WRAP = SW'(WRAP_TO);
   localparam logic [SW-1:0] RST  = SW'(RESET_STATE);
   localparam logic [SW:0]   NS_X = (SW+1)'(NUM_STATES);

   logic [SW-1:0]         state;
   logic [SW-1:0]         state_nx;
   logic [NUM_STATES-1:0] pattern;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nx;
   logic [CNT_W-1:0]      count_inc;
   logic                  prev;
   logic                  step;
   logic                  wrap_q;
   logic                  wrap_nx;
   logic                  lerr_q;
   logic                  lerr_nx;
   act_t                  act;

   // prev resets high so a data_in held through reset is not an edge
   assign step = (EDGE_MODE != 0) ? (data_in & ~prev) : data_in;

   // priority: load > hold > step > idle
   always_comb begin
      act = ACT_IDLE;
      if (load) begin
         if ({1'b0, load_state} < NS_X) act = ACT_LOAD;
         else                           act = ACT_LERR;
      end else if (hold) begin
         act = ACT_HOLD;
      end else if (step) begin
         act = dir ? ACT_BWD : ACT_FWD;
      end
   end

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      wrap_nx   = 1'b0;
      lerr_nx   = 1'b0;
      count_inc = (&count) ? count : count + 1'b1;
      unique case (act)
         ACT_LOAD: begin
            state_nx = load_state;
            count_nx = '0;
         end
         ACT_LERR: lerr_nx = 1'b1;
         ACT_FWD: begin
            count_nx = count_inc;
            if (state == LAST) begin
               state_nx = WRAP;
               wrap_nx  = 1'b1;
            end else begin
               state_nx = state + 1'b1;
            end
         end
         ACT_BWD: begin
            count_nx = count_inc;
            // states below WRAP_TO are entry-only, never re-entered
            if (state <= WRAP) begin
               state_nx = LAST;
               wrap_nx  = 1'b1;
            end else begin
               state_nx = state - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RST;
         pattern <= OUT_PATTERN;
         count   <= '0;
         prev    <= 1'b1;
         wrap_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         count  <= count_nx;
         prev   <= data_in;
         wrap_q <= wrap_nx;
         lerr_q <= lerr_nx;
         if (pat_we) pattern <= pat_in;
      end
   end

   assign data_out   = pattern[state];
   assign state_out  = state;
   assign wrap_pulse = wrap_q;
   assign load_err   = lerr_q;
   assign step_count = count;

endmodule

// File: tb/tb_step_ring_fsm.sv
// tb_step_ring_fsm: four step_ring_fsm variants driven in lockstep,
// checked each cycle against an integer model of the ring rules.
module tb_step_ring_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        di = 1'b0;
   logic        dr = 1'b0;
   logic        hd = 1'b0;
   logic        lo = 1'b0;
   logic [3:0]  ld = 4'd0;
   logic        pwe = 1'b0;
   logic [15:0] pin = 16'd0;

   logic       d0, d1, d2, d3;
   logic [1:0] st0, st1, st2;
   logic [2:0] st3;
   logic       w0, w1, w2, w3;
   logic       e0, e1, e2, e3;
   logic [7:0] c0, c1;
   logic [1:0] c2;
   logic [3:0] c3;

   int vecs = 0;
   int miss = 0;

   int ns[4], rs[4], wt[4], op[4], em[4], cmax[4], swm[4];
   int ms[4], mc[4], mp[4], mpat[4], mw[4], ml[4];

   always #5 clk = ~clk;

   step_ring_fsm u0 (
      .clk(clk), .reset(rst), .data_in(di), .dir(dr), .hold(hd),
      .load(lo), .load_state(ld[1:0]), .pat_we(pwe), .pat_in(pin[3:0]),
      .data_out(d0), .state_out(st0), .wrap_pulse(w0),
      .load_err(e0), .step_count(c0));

   step_ring_fsm #(.EDGE_MODE(1)) u1 (
      .clk(clk), .reset(rst), .data_in(di), .dir(dr), .hold(hd),
      .load(lo), .load_state(ld[1:0]), .pat_we(pwe), .pat_in(pin[3:0]),
      .data_out(d1), .state_out(st1), .wrap_pulse(w1),
      .load_err(e1), .step_count(c1));

   step_ring_fsm #(.CNT_W(2)) u2 (
      .clk(clk), .reset(rst), .data_in(di), .dir(dr), .hold(hd),
      .load(lo), .load_state(ld[1:0]), .pat_we(pwe), .pat_in(pin[3:0]),
      .data_out(d2), .state_out(st2), .wrap_pulse(w2),
      .load_err(e2), .step_count(c2));

   step_ring_fsm #(
      .NUM_STATES(6), .RESET_STATE(3), .WRAP_TO(2),
      .OUT_PATTERN(6'b110010), .CNT_W(4)
   ) u3 (
      .clk(clk), .reset(rst), .data_in(di), .dir(dr), .hold(hd),
      .load(lo), .load_state(ld[2:0]), .pat_we(pwe), .pat_in(pin[5:0]),
      .data_out(d3), .state_out(st3), .wrap_pulse(w3),
      .load_err(e3), .step_count(c3));

   function automatic logic [31:0] g_st(int i);
      case (i)
         0: return 32'(st0);
         1: return 32'(st1);
         2: return 32'(st2);
         default: return 32'(st3);
      endcase
   endfunction

   function automatic logic [31:0] g_do(int i);
      case (i)
         0: return 32'(d0);
         1: return 32'(d1);
         2: return 32'(d2);
         default: return 32'(d3);
      endcase
   endfunction

   function automatic logic [31:0] g_wp(int i);
      case (i)
         0: return 32'(w0);
         1: return 32'(w1);
         2: return 32'(w2);
         default: return 32'(w3);
      endcase
   endfunction

   function automatic logic [31:0] g_le(int i);
      case (i)
         0: return 32'(e0);
         1: return 32'(e1);
         2: return 32'(e2);
         default: return 32'(e3);
      endcase
   endfunction

   function automatic logic [31:0] g_cnt(int i);
      case (i)
         0: return 32'(c0);
         1: return 32'(c1);
         2: return 32'(c2);
         default: return 32'(c3);
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_upd(int i);
      int lsv;
      int stp;
      if (rst) begin
         ms[i] = rs[i]; mpat[i] = op[i]; mc[i] = 0;
         mw[i] = 0; ml[i] = 0; mp[i] = 1;
         return;
      end
      stp = (em[i] != 0) ? int'(di && (mp[i] == 0)) : int'(di);
      mp[i] = int'(di);
      mw[i] = 0;
      ml[i] = 0;
      lsv = int'(ld) & swm[i];
      if (lo) begin
         if (lsv < ns[i]) begin
            ms[i] = lsv;
            mc[i] = 0;
         end else begin
            ml[i] = 1;
         end
      end else if (!hd && stp != 0) begin
         if (!dr) begin
            if (ms[i] == ns[i] - 1) begin ms[i] = wt[i]; mw[i] = 1; end
            else ms[i] = ms[i] + 1;
         end else begin
            if (ms[i] <= wt[i]) begin ms[i] = ns[i] - 1; mw[i] = 1; end
            else ms[i] = ms[i] - 1;
         end
         mc[i] = (mc[i] + 1 > cmax[i]) ? cmax[i] : mc[i] + 1;
      end
      if (pwe) mpat[i] = int'(pin) & ((1 << ns[i]) - 1);
   endtask

   task automatic check_all(int i);
      chk($sformatf("u%0d state", i), g_st(i), 32'(ms[i]));
      chk($sformatf("u%0d data_out", i), g_do(i), 32'((mpat[i] >> ms[i]) & 1));
      chk($sformatf("u%0d wrap", i), g_wp(i), 32'(mw[i]));
      chk($sformatf("u%0d load_err", i), g_le(i), 32'(ml[i]));
      chk($sformatf("u%0d count", i), g_cnt(i), 32'(mc[i]));
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_upd(i);
      #1;
      for (int i = 0; i < 4; i++) check_all(i);
   endtask

   initial begin
      ns   = '{4, 4, 4, 6};
      rs   = '{1, 1, 1, 3};
      wt   = '{1, 1, 1, 2};
      op   = '{10, 10, 10, 50};
      em   = '{0, 1, 0, 0};
      cmax = '{255, 255, 3, 15};
      swm  = '{3, 3, 3, 7};
      for (int i = 0; i < 4; i++) begin
         ms[i] = 0; mc[i] = 0; mp[i] = 0;
         mpat[i] = 0; mw[i] = 0; ml[i] = 0;
      end

      // reset with data_in high through release
      rst = 1'b1; di = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      repeat (5) cycle();
      chk("plan fwd state", 32'(st0), 32'd3);
      chk("plan fwd count", 32'(c0), 32'd5);
      chk("plan edge no step", 32'(st1), 32'd1);
      chk("plan edge count", 32'(c1), 32'd0);
      chk("plan sat count", 32'(c2), 32'd3);

      // edge mode: low then high gives one step
      di = 1'b0; cycle();
      di = 1'b1; cycle();
      chk("plan edge step", 32'(st1), 32'd2);

      // backward from state 1
      di = 1'b0; lo = 1'b1; ld = 4'd1; cycle();
      lo = 1'b0; di = 1'b1; dr = 1'b1;
      cycle();
      chk("plan bwd wrap", 32'(w0), 32'd1);
      cycle();
      chk("plan bwd state", 32'(st0), 32'd2);
      chk("plan bwd count", 32'(c0), 32'd2);
      dr = 1'b0;

      // loads, including out-of-range for the 6-state ring
      lo = 1'b1; ld = 4'd0; cycle();
      ld = 4'd5; cycle();
      ld = 4'd7; cycle();
      chk("plan load_err", 32'(e3), 32'd1);
      lo = 1'b0; di = 1'b0; cycle();

      // hold freezes, then pattern write in state 2
      hd = 1'b1; di = 1'b1;
      repeat (3) cycle();
      hd = 1'b0; di = 1'b0; lo = 1'b1; ld = 4'd2; cycle();
      lo = 1'b0; pwe = 1'b1; pin = 16'h0005; cycle();
      chk("plan pattern", 32'(d0), 32'd1);
      pwe = 1'b0;

      // saturating counter then reset mid-sequence
      di = 1'b1;
      repeat (6) cycle();
      rst = 1'b1; cycle();
      rst = 1'b0; di = 1'b0; cycle();
      chk("plan reset pattern", 32'(d0), 32'd1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         di  = ($urandom_range(0, 1) == 1);
         dr  = ($urandom_range(0, 2) == 0);
         hd  = ($urandom_range(0, 7) == 0);
         lo  = ($urandom_range(0, 7) == 0);
         ld  = 4'($urandom_range(0, 7));
         pwe = ($urandom_range(0, 9) == 0);
         pin = 16'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
